// File: rtl/uart_serdes_core_if.sv
// Byte-stream interface of uart_serdes_core: TX valid/ready stream in,
// RX valid/ready stream out with its per-character status flags.
// master = stream producer/consumer outside the core, slave = the core.
interface uart_serdes_core_if #(
  parameter int MAX_DATA_BITS = 8
);
  logic [MAX_DATA_BITS-1:0] tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [MAX_DATA_BITS-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic                     rx_frame_err;
  logic                     rx_parity_err;
  logic                     rx_break;
  logic                     rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err,
           rx_break, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err,
           rx_break, rx_overrun
  );
endinterface

// File: rtl/uart_serdes_core.sv
// uart_serdes_core: single-clock UART serializer/deserializer with
// independent TX/RX FSMs, per-direction prescaler + oversample counter,
// 5..MAX_DATA_BITS data bits, 1/2 stop bits, break detection.
// Optional parity: define UART_PARITY_EN to honour cfg_parity; otherwise
// parity is ignored and rx_parity_err stays 0.
module uart_serdes_core #(
  parameter int DIV_WIDTH     = 16,
  parameter int MAX_DATA_BITS = 8,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] cfg_divisor,
  input  logic [3:0]           cfg_data_bits,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic                 cfg_enable,
  uart_serdes_core_if.slave    bus,
  output logic                 tx_busy,
  output logic                 rx_busy,
  output logic                 uart_tx,
  input  logic                 uart_rx
);
`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam int             OSW     = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     MAXB    = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [3:0]               cfg_nb;
  logic [MAX_DATA_BITS-1:0] cfg_mask;
  logic                     par_cfg;

  // Clamp character length, build the data mask, decode parity enable
  always_comb begin
    cfg_nb = cfg_data_bits;
    if (cfg_data_bits < 4'd5)     cfg_nb = 4'd5;
    else if (cfg_data_bits > MAXB) cfg_nb = MAXB;
    cfg_mask = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) cfg_mask[i] = (i < int'(cfg_nb));
    par_cfg = PAR_EN & (cfg_parity[0] ^ cfg_parity[1]);
  end

  // ---------------- TX ----------------
  state_t                   tx_state_q;
  logic [DIV_WIDTH-1:0]     tx_div_q, tx_presc_q, tx_presc_d;
  logic [OSW-1:0]           tx_os_q, tx_os_d;
  logic [MAX_DATA_BITS-1:0] tx_shift_q;
  logic [3:0]               tx_nb_q, tx_cnt_q;
  logic                     tx_par_en_q, tx_par_q, tx_stop2_q, tx_stop_cnt_q;
  logic                     tx_ready_q, tx_busy_q, uart_tx_q;
  logic                     tx_tick, tx_bit_end;

  // TX bit timing: prescaler tick, oversample count, end of bit
  always_comb begin
    tx_tick    = (tx_presc_q == tx_div_q);
    tx_presc_d = tx_tick ? '0 : tx_presc_q + 1'b1;
    tx_os_d    = tx_os_q;
    if (tx_tick) tx_os_d = (tx_os_q == OS_LAST) ? '0 : tx_os_q + 1'b1;
    tx_bit_end = tx_tick && (tx_os_q == OS_LAST);
  end

  // TX FSM with registered line, ready and busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= IDLE;  tx_div_q <= '0;   tx_presc_q <= '0;  tx_os_q <= '0;
      tx_shift_q <= '0;    tx_nb_q <= 4'd5;  tx_cnt_q <= '0;
      tx_par_en_q <= 1'b0; tx_par_q <= 1'b0; tx_stop2_q <= 1'b0; tx_stop_cnt_q <= 1'b0;
      tx_ready_q <= 1'b0;  tx_busy_q <= 1'b0; uart_tx_q <= 1'b1;
    end else begin
      tx_presc_q <= tx_presc_d;
      tx_os_q    <= tx_os_d;
      case (tx_state_q)
        IDLE: begin
          tx_presc_q <= '0;
          tx_os_q    <= '0;
          tx_ready_q <= cfg_enable;
          if (bus.tx_valid && tx_ready_q) begin
            tx_state_q    <= START;
            tx_ready_q    <= 1'b0;
            tx_busy_q     <= 1'b1;
            uart_tx_q     <= 1'b0;
            tx_div_q      <= cfg_divisor;
            tx_nb_q       <= cfg_nb;
            tx_shift_q    <= bus.tx_data & cfg_mask;
            tx_par_en_q   <= par_cfg;
            tx_par_q      <= (^(bus.tx_data & cfg_mask)) ^ cfg_parity[1];
            tx_stop2_q    <= cfg_stop2;
            tx_stop_cnt_q <= 1'b0;
            tx_cnt_q      <= '0;
          end
        end
        START: if (tx_bit_end) begin
          tx_state_q <= DATA;
          uart_tx_q  <= tx_shift_q[0];
          tx_shift_q <= tx_shift_q >> 1;
        end
        DATA: if (tx_bit_end) begin
          if (tx_cnt_q == tx_nb_q - 4'd1) begin
            tx_state_q <= tx_par_en_q ? PARITY : STOP;
            uart_tx_q  <= tx_par_en_q ? tx_par_q : 1'b1;
          end else begin
            uart_tx_q  <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_cnt_q   <= tx_cnt_q + 4'd1;
          end
        end
        PARITY: if (tx_bit_end) begin
          tx_state_q <= STOP;
          uart_tx_q  <= 1'b1;
        end
        STOP: if (tx_bit_end) begin
          if (tx_stop2_q && !tx_stop_cnt_q) begin
            tx_stop_cnt_q <= 1'b1;
          end else begin
            tx_state_q <= IDLE;
            tx_busy_q  <= 1'b0;
            tx_ready_q <= cfg_enable;
          end
        end
        default: begin
          tx_state_q <= IDLE;
          tx_busy_q  <= 1'b0;
          uart_tx_q  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [1:0]               rx_sync_q;
  logic                     rx_prev_q;
  state_t                   rx_state_q;
  logic [DIV_WIDTH-1:0]     rx_div_q, rx_presc_q, rx_presc_d;
  logic [OSW-1:0]           rx_os_q, rx_os_d;
  logic [MAX_DATA_BITS-1:0] rx_shift_q, rx_data_q, rx_data_d;
  logic [3:0]               rx_nb_q, rx_cnt_q;
  logic                     rx_par_en_q, rx_odd_q, rx_acc_q, rx_psample_q;
  logic                     rx_busy_q, rx_valid_q, rx_ferr_q, rx_perr_q, rx_brk_q, rx_ovr_q;
  logic                     rx_bit, rx_tick, rx_sample;

  // Two-flop synchronizer plus previous sample for start-edge detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx};
      rx_prev_q <= rx_sync_q[1];
    end
  end

  // RX bit timing: mid-bit sample strobe and right-aligned character
  always_comb begin
    rx_bit     = rx_sync_q[1];
    rx_tick    = (rx_presc_q == rx_div_q);
    rx_presc_d = rx_tick ? '0 : rx_presc_q + 1'b1;
    rx_os_d    = rx_os_q;
    if (rx_tick) rx_os_d = (rx_os_q == OS_LAST) ? '0 : rx_os_q + 1'b1;
    rx_sample  = rx_tick && (rx_os_q == OS_MID);
    rx_data_d  = rx_shift_q >> (MAXB - rx_nb_q);
  end

  // RX FSM, one-entry output buffer and overrun pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= IDLE;  rx_div_q <= '0;    rx_presc_q <= '0;  rx_os_q <= '0;
      rx_shift_q <= '0;    rx_data_q <= '0;   rx_nb_q <= 4'd5;   rx_cnt_q <= '0;
      rx_par_en_q <= 1'b0; rx_odd_q <= 1'b0;  rx_acc_q <= 1'b0;  rx_psample_q <= 1'b0;
      rx_busy_q <= 1'b0;   rx_valid_q <= 1'b0; rx_ferr_q <= 1'b0; rx_perr_q <= 1'b0;
      rx_brk_q <= 1'b0;    rx_ovr_q <= 1'b0;
    end else begin
      rx_ovr_q   <= 1'b0;
      rx_presc_q <= rx_presc_d;
      rx_os_q    <= rx_os_d;
      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
      if (!cfg_enable) begin
        rx_state_q <= IDLE;
        rx_busy_q  <= 1'b0;
      end else begin
        case (rx_state_q)
          IDLE: begin
            rx_presc_q <= '0;
            rx_os_q    <= '0;
            if (!rx_bit && rx_prev_q) begin
              rx_state_q  <= START;
              rx_busy_q   <= 1'b1;
              rx_div_q    <= cfg_divisor;
              rx_nb_q     <= cfg_nb;
              rx_par_en_q <= par_cfg;
              rx_odd_q    <= cfg_parity[1];
              rx_shift_q  <= '0;
              rx_cnt_q    <= '0;
              rx_acc_q    <= 1'b0;
              rx_psample_q <= 1'b0;
            end
          end
          START: if (rx_sample) begin
            if (rx_bit) begin
              rx_state_q <= IDLE;
              rx_busy_q  <= 1'b0;
            end else begin
              rx_state_q <= DATA;
            end
          end
          DATA: if (rx_sample) begin
            rx_shift_q <= {rx_bit, rx_shift_q[MAX_DATA_BITS-1:1]};
            rx_acc_q   <= rx_acc_q ^ rx_bit;
            if (rx_cnt_q == rx_nb_q - 4'd1) rx_state_q <= rx_par_en_q ? PARITY : STOP;
            else                            rx_cnt_q   <= rx_cnt_q + 4'd1;
          end
          PARITY: if (rx_sample) begin
            rx_psample_q <= rx_bit;
            rx_state_q   <= STOP;
          end
          STOP: if (rx_sample) begin
            rx_state_q <= IDLE;
            rx_busy_q  <= 1'b0;
            if (rx_valid_q && !bus.rx_ready) begin
              rx_ovr_q <= 1'b1;
            end else begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= rx_data_d;
              rx_ferr_q  <= !rx_bit;
              rx_perr_q  <= rx_par_en_q & (rx_acc_q ^ rx_psample_q ^ rx_odd_q);
              rx_brk_q   <= (rx_data_d == '0) && !rx_bit && !(rx_par_en_q && rx_psample_q);
            end
          end
          default: begin
            rx_state_q <= IDLE;
            rx_busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tx_ready      = tx_ready_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_break      = rx_brk_q;
  assign bus.rx_overrun    = rx_ovr_q;
  assign tx_busy           = tx_busy_q;
  assign rx_busy           = rx_busy_q;
  assign uart_tx           = uart_tx_q;
endmodule

// File: tb/tb_uart_serdes_core.sv
// Directed bench for uart_serdes_core at divisor 3 / oversample 16
// (64 clk per bit). Parity expectations follow UART_PARITY_EN.
module tb_uart_serdes_core;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BITT = 64;
  localparam int LIM  = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_divisor = 16'd3;
  logic [3:0]  cfg_data_bits = 4'd8;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic        cfg_enable = 1'b1;
  logic        tx_busy, rx_busy, uart_tx, uart_rx;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_cnt = 0;
  logic [10:0] rxq[$];

  always #5 clk = ~clk;
  assign uart_rx = loop ? uart_tx : rx_drv;

  uart_serdes_core_if #(.MAX_DATA_BITS(8)) bus();

  uart_serdes_core #(.DIV_WIDTH(16), .MAX_DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_divisor(cfg_divisor), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_enable(cfg_enable),
    .bus(bus), .tx_busy(tx_busy), .rx_busy(rx_busy), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  // Log handshaken characters {break, parity_err, frame_err, data} and overrun pulses
  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready)
      rxq.push_back({bus.rx_break, bus.rx_parity_err, bus.rx_frame_err, bus.rx_data});
    if (bus.rx_overrun) ovr_cnt++;
  end

  // Present a byte, wait for acceptance; returns at the negedge of cycle 1
  task automatic send_byte(input logic [7:0] d, output int waited);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    waited = 0;
    while (bus.tx_ready !== 1'b1 && waited < LIM) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Drive one serial frame on uart_rx followed by one idle bit
  task automatic rx_send(input logic [7:0] d, input int nb, input bit hp,
                         input logic pb, input logic sb);
    rx_drv = 1'b0;
    repeat (BITT) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx_drv = d[i];
      repeat (BITT) @(negedge clk);
    end
    if (hp) begin
      rx_drv = pb;
      repeat (BITT) @(negedge clk);
    end
    rx_drv = sb;
    repeat (BITT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BITT) @(negedge clk);
  endtask

  // Wait (bounded) for a buffered character, capture it, then hand it off
  task automatic rx_pop(output logic got, output logic [10:0] v);
    int n;
    got = 1'b0;
    v = '0;
    n = 0;
    while (bus.rx_valid !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_valid === 1'b1) begin
      got = 1'b1;
      v = {bus.rx_break, bus.rx_parity_err, bus.rx_frame_err, bus.rx_data};
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({uart_tx, bus.tx_ready, bus.rx_valid} !== 3'b100) begin
        n_bad++;
        $display("FAIL reset_c%0d: {uart_tx,tx_ready,rx_valid}=%b required 100", c,
                 {uart_tx, bus.tx_ready, bus.rx_valid});
      end
      bus.tx_valid = ~bus.tx_valid;
      bus.tx_data  = 8'($urandom);
      rx_drv       = ~rx_drv;
    end
    bus.tx_valid = 1'b0;
    rx_drv = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.tx_ready, tx_busy, rx_busy, bus.rx_data} !== {3'b100, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_release: {tx_ready,tx_busy,rx_busy,rx_data}=%b required 100_00000000",
               {bus.tx_ready, tx_busy, rx_busy, bus.rx_data});
    end
  endtask

  task automatic test_tx_8n1;
    logic [9:0] frame;
    int w, bad;
    logic e;
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    frame = {1'b1, 8'hA5, 1'b0};
    send_byte(8'hA5, w);
    n_cmp++;
    if (bus.tx_ready !== 1'b0 || tx_busy !== 1'b1 || w != 0) begin
      n_bad++;
      $display("FAIL tx_accept: tx_ready=%b tx_busy=%b waited=%0d required 0 1 0",
               bus.tx_ready, tx_busy, w);
    end
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      e = frame[k];
      for (int c = 0; c < BITT; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        if (uart_tx !== e) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL tx_bit%0d: uart_tx wrong in %0d of 64 cycles, required %b", k, bad, e);
      end
    end
    n_cmp++;
    if (bus.tx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_ready_c640: got %b required 0", bus.tx_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.tx_ready !== 1'b1 || tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL tx_ready_c641: tx_ready=%b tx_busy=%b uart_tx=%b required 1 0 1",
               bus.tx_ready, tx_busy, uart_tx);
    end
  endtask

  task automatic test_loopback;
    int w1, w2, n, frame_len;
    cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    frame_len = (1 + 7 + PAR + 2) * BITT;
    bus.rx_ready = 1'b1;
    loop = 1'b1;
    rxq.delete();
    send_byte(8'h55, w1);
    send_byte(8'h2A, w2);
    n_cmp++;
    if (w2 != frame_len) begin
      n_bad++;
      $display("FAIL loop_b2b_gap: second accept after %0d cycles required %0d", w2, frame_len);
    end
    n = 0;
    while (rxq.size() < 2 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (rxq.size() != 2) begin
      n_bad++;
      $display("FAIL loop_count: received %0d characters required 2", rxq.size());
    end else begin
      n_cmp++;
      if (rxq[0] !== {3'b000, 8'h55}) begin
        n_bad++;
        $display("FAIL loop_rx0: got %h required %h", rxq[0], {3'b000, 8'h55});
      end
      n_cmp++;
      if (rxq[1] !== {3'b000, 8'h2A}) begin
        n_bad++;
        $display("FAIL loop_rx1: got %h required %h", rxq[1], {3'b000, 8'h2A});
      end
    end
    n = 0;
    while (tx_busy !== 1'b0 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    rx_drv = 1'b1;
    loop = 1'b0;
    bus.rx_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_errors;
    logic got;
    logic [10:0] v;
    cfg_data_bits = 4'd7; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
    // 0x41 has two ones: the correct odd parity bit is 1, send 0
    rx_send(8'h41, 7, PAR != 0, 1'b0, 1'b1);
    rx_pop(got, v);
    n_cmp++;
    if (!got || v !== {1'b0, PAR == 1, 1'b0, 8'h41}) begin
      n_bad++;
      $display("FAIL parity_err: got=%b v=%h required %h", got, v, {1'b0, PAR == 1, 1'b0, 8'h41});
    end
    // 0x3C has four ones: parity bit 1 is correct; stop bit forced 0
    rx_send(8'h3C, 7, PAR != 0, 1'b1, 1'b0);
    rx_pop(got, v);
    n_cmp++;
    if (!got || v !== {3'b001, 8'h3C}) begin
      n_bad++;
      $display("FAIL frame_err: got=%b v=%h required %h", got, v, {3'b001, 8'h3C});
    end
  endtask

  task automatic test_break;
    logic got;
    logic [10:0] v;
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    rx_drv = 1'b0;
    repeat (12 * BITT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BITT) @(negedge clk);
    rx_pop(got, v);
    n_cmp++;
    if (!got || v !== {3'b101, 8'h00}) begin
      n_bad++;
      $display("FAIL break: got=%b v=%h required %h", got, v, {3'b101, 8'h00});
    end
    repeat (2 * BITT) @(negedge clk);
    n_cmp++;
    if (bus.rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL break_single: rx_valid=%b required 0", bus.rx_valid);
    end
    // one-tick low glitch is a false start
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * BITT) @(negedge clk);
    n_cmp++;
    if (bus.rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL false_start: rx_valid=%b rx_busy=%b required 0 0", bus.rx_valid, rx_busy);
    end
  endtask

  task automatic test_overrun;
    logic got;
    logic [10:0] v;
    int o0;
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    bus.rx_ready = 1'b0;
    o0 = ovr_cnt;
    rx_send(8'h11, 8, 1'b0, 1'b0, 1'b1);
    rx_send(8'h22, 8, 1'b0, 1'b0, 1'b1);
    rx_send(8'h33, 8, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
      n_bad++;
      $display("FAIL overrun_hold: rx_valid=%b rx_data=%h required 1 11", bus.rx_valid, bus.rx_data);
    end
    n_cmp++;
    if (ovr_cnt - o0 != 2) begin
      n_bad++;
      $display("FAIL overrun_pulses: got %0d required 2", ovr_cnt - o0);
    end
    rx_pop(got, v);
    // buffer 0x55, then accept the buffer in the cycle 0x66 completes
    rx_send(8'h55, 8, 1'b0, 1'b0, 1'b1);
    o0 = ovr_cnt;
    fork
      rx_send(8'h66, 8, 1'b0, 1'b0, 1'b1);
      begin
        repeat (610) @(posedge clk);
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        n_cmp++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h66) begin
          n_bad++;
          $display("FAIL same_cycle_load: rx_valid=%b rx_data=%h required 1 66",
                   bus.rx_valid, bus.rx_data);
        end
      end
    join
    n_cmp++;
    if (ovr_cnt != o0) begin
      n_bad++;
      $display("FAIL same_cycle_no_ovr: %0d overrun pulses required 0", ovr_cnt - o0);
    end
    rx_pop(got, v);
  endtask

  task automatic test_enable;
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (rx_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rx_busy_mid: got %b required 1", rx_busy);
    end
    cfg_enable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rx_busy !== 1'b0 || bus.tx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL disable: rx_busy=%b tx_ready=%b required 0 0", rx_busy, bus.tx_ready);
    end
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    cfg_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.tx_ready !== 1'b1 || bus.rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reenable: tx_ready=%b rx_valid=%b required 1 0", bus.tx_ready, bus.rx_valid);
    end
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_tx_8n1();
    test_loopback();
    test_errors();
    test_break();
    test_overrun();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_serdes_core.md
# uart_serdes_core

Single-clock, runtime-configurable UART serializer/deserializer. It has independent TX and RX state machines, per-direction fractional-free baud prescalers, and valid/ready byte streams, with no clock-domain crossing. It is the successor engine beneath the register/FIFO layer: it generalises the fixed 8N1 path to 5..MAX_DATA_BITS data bits, optional parity, 1 or 2 stop bits, and break detection.

## Interface
- DIV_WIDTH, 16: width of baud divisor.
- MAX_DATA_BITS, 8: widest supported character (≥5).
- OVERSAMPLE, 16: prescaler ticks per bit; even, ≥4.
- clk  in  1  system clock; sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_divisor  in  DIV_WIDTH  tick period = cfg_divisor+1 clk cycles.
- cfg_data_bits  in  4  characters length; <5 treated as 5, >MAX_DATA_BITS as MAX_DATA_BITS.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- cfg_stop2  in  1  1 = two TX stop bits.
- cfg_enable  in  1  engine enable.
- tx_data  in  MAX_DATA_BITS  character, LSB first; unused MSBs ignored.
- tx_valid  in  1  / tx_ready  out  1  TX stream handshake.
- rx_data  out  MAX_DATA_BITS  received character, unused MSBs zero.
- rx_valid  out  1  / rx_ready  in  1  RX stream handshake.
- rx_frame_err, rx_parity_err, rx_break  out  1 each  status qualifying rx_data; valid while rx_valid.
- rx_overrun  out  1  one-cycle pulse, frame dropped.
- tx_busy, rx_busy  out  1  FSM not IDLE.
- uart_tx  out  1  serial out, idle high.
- uart_rx  in  1  serial in, asynchronous.

## Operation
- All outputs are registered. Reset values: uart_tx=1, tx_ready=0, tx_busy=0, rx_busy=0, rx_valid=0, rx_data=0, all error flags 0. RX synchronizer resets to 1.
- cfg_* is latched at TX accept and at RX start detect. Changes mid-frame do not affect the current frame.
- Each direction owns a prescaler and an oversample counter. Both restart at frame start.
- TX FSM: IDLE→START→DATA→[PARITY]→STOP→IDLE.
  - tx_ready=1 only in IDLE with cfg_enable=1.
  - Accept on tx_valid&&tx_ready.
  - Each bit lasts OVERSAMPLE ticks.
  - Parity bit is XOR of data bits, inverted for odd.
  - STOP lasts 1 or 2 bits.
- RX front end: 2-flop synchronizer. The start edge is sync=0 while the previous sample=1, detected in IDLE only.
- RX FSM: IDLE→START→DATA→[PARITY]→STOP→IDLE.
  - Each bit is sampled at OVERSAMPLE/2 ticks into the bit.
  - START sample =1 is a false start; return to IDLE with no output.
  - Only the first stop bit is checked. RX returns to IDLE at mid-stop.
- Frame completion:
  - frame_err = stop sample 0.
  - parity_err = parity mismatch, only when parity is enabled.
  - break = data zero, parity sample zero (if present), and stop zero. frame_err is also set.
- Output buffer: one entry. rx_valid holds with stable data and flags until rx_valid&&rx_ready.
- Overrun: a frame completes while rx_valid=1 and no handshake occurs that cycle. The new frame is discarded and rx_overrun pulses.
  - If the handshake happens in the same cycle, the new frame loads and there is no overrun.
- cfg_enable=0:
  - TX finishes the current frame, then holds IDLE with tx_ready=0.
  - RX aborts any partial frame to IDLE immediately. Buffered rx_valid data is retained.
- Reset mid-frame: both FSMs go to IDLE next edge, with uart_tx=1 and the buffer cleared.

## Timing
- Tick t: prescaler reaches cfg_divisor. cfg_divisor=0 gives a tick every cycle.
- Bit time = OVERSAMPLE×(cfg_divisor+1) clk cycles.
- TX:
  - uart_tx goes low the cycle after accept.
  - Frame = (1 + N + P + S)×bit time.
  - tx_ready reasserts the cycle after the final stop bit ends.
  - Back-to-back accepts produce contiguous frames, with no idle gap beyond that one cycle.
- RX:
  - Start detect occurs 2 cycles after the uart_rx fall (synchronizer).
  - rx_valid rises the cycle after the stop-sample tick.
- tx_ready and rx_valid update on the clock after the handshake.

## Configuration
- UART_PARITY_EN defined: cfg_parity is honoured on TX and RX, and rx_parity_err is functional.
- Undefined: cfg_parity is ignored (treated as none), no parity bit or PARITY state is generated, and rx_parity_err is tied 0.

## Test plan
- Reset with rst_n=0 for 3 cycles, stimulus toggling → uart_tx=1, tx_ready=0, rx_valid=0 throughout. tx_ready=1 one cycle after release with cfg_enable=1.
- Divisor 3, 8N1, send 0xA5:
  - uart_tx low for cycles 1–64.
  - Then bits 1,0,1,0,0,1,0,1, each 64 cycles.
  - Stop bit high cycles 577–640.
  - tx_ready=1 at cycle 641.
- Loopback uart_tx→uart_rx, 7E2 (UART_PARITY_EN), send 0x55 then 0x2A back-to-back → rx_data=0x55 then 0x2A, no error flags, and the second frame starts immediately after the 2-bit stop.
- Drive a 7O1 frame with a wrong parity bit, then a frame with stop=0 and data 0x3C → first: rx_parity_err=1. Second: rx_frame_err=1, rx_break=0.
- Hold uart_rx low for 12 bit times (8N1) → rx_data=0x00, rx_frame_err=1, rx_break=1. A 1-tick low glitch gives no rx_valid (false start).
- rx_ready=0, three frames 0x11, 0x22, 0x33 → rx_data stays 0x11. rx_overrun pulses twice, once per dropped frame. Raising rx_ready in the completion cycle of a frame loads it with no overrun.
